lcd_timing_gen: RTL

//  Free-running raster timing generator for the 800x480 RGB LCD panel. Drives the panel

---
 rtl/lcd_timing_if.sv | 31 +++
 rtl/lcd_timing_gen.sv | 126 ++++++++++++
 2 files changed

// File: rtl/lcd_timing_if.sv
`default_nettype none
// ============================================================================
// Module      : lcd_timing_if
// Description : Enable input plus raster sync/coordinate outputs of the LCD
//               timing generator.
// Revision    : 1.0 - initial release
// ============================================================================
interface lcd_timing_if;
    logic        Enable;
    logic [15:0] PixelCount;
    logic [15:0] LineCount;
    logic        LCD_DEN;
    logic        LCD_HSYNC;
    logic        LCD_VSYNC;
    logic        LineStart;
    logic        FrameStart;
    logic [15:0] FrameCount;

    modport master (
        input  Enable,
        output PixelCount, LineCount, LCD_DEN, LCD_HSYNC, LCD_VSYNC,
               LineStart, FrameStart, FrameCount
    );

    modport slave (
        output Enable,
        input  PixelCount, LineCount, LCD_DEN, LCD_HSYNC, LCD_VSYNC,
               LineStart, FrameStart, FrameCount
    );
endinterface
`default_nettype wire

// File: rtl/lcd_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : lcd_timing_gen
// Description : Free-running raster timing generator for an RGB LCD panel.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_timing_gen #(
    parameter int H_ACTIVE     = 800,
    parameter int H_FRONT      = 40,
    parameter int H_SYNC       = 48,
    parameter int H_BACK       = 88,
    parameter int V_ACTIVE     = 480,
    parameter int V_FRONT      = 13,
    parameter int V_SYNC       = 3,
    parameter int V_BACK       = 32,
    parameter bit SYNC_ACT_LOW = 1'b1
) (
    input  wire logic    PixelClk,
    input  wire logic    Reset,
    lcd_timing_if.master bus
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [15:0] H_LAST    = 16'(H_TOTAL - 1);
    localparam logic [15:0] V_LAST    = 16'(V_TOTAL - 1);
    localparam logic [15:0] H_ACT16   = 16'(H_ACTIVE);
    localparam logic [15:0] V_ACT16   = 16'(V_ACTIVE);
    localparam logic [15:0] HS_BEGIN  = 16'(H_ACTIVE + H_FRONT);
    localparam logic [15:0] HS_END    = 16'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [15:0] VS_BEGIN  = 16'(V_ACTIVE + V_FRONT);
    localparam logic [15:0] VS_END    = 16'(V_ACTIVE + V_FRONT + V_SYNC);
    localparam logic        SYNC_ON   = ~SYNC_ACT_LOW;
    localparam logic        SYNC_OFF  = SYNC_ACT_LOW;
    localparam logic [15:0] COORD_OFF = 16'hFFFF;

    logic [15:0] h_q, h_d, v_q, v_d;
    logic [15:0] px_q, px_d, ln_q, ln_d, fc_q, fc_d;
    logic        den_q, den_d, hs_q, hs_d, vs_q, vs_d;
    logic        ls_q, ls_d, fs_q, fs_d, first_q, first_d;

    logic [15:0] h_nxt, v_nxt;
    logic        den_nxt;

    // Outputs are derived from the upcoming position so they line up with h/v.
    always_comb begin
        h_nxt   = (h_q == H_LAST) ? 16'd0 : h_q + 16'd1;
        v_nxt   = v_q;
        if (h_q == H_LAST) begin
            v_nxt = (v_q == V_LAST) ? 16'd0 : v_q + 16'd1;
        end
        den_nxt = (h_nxt < H_ACT16) && (v_nxt < V_ACT16);

        h_d     = h_q;
        v_d     = v_q;
        px_d    = px_q;
        ln_d    = ln_q;
        den_d   = den_q;
        hs_d    = hs_q;
        vs_d    = vs_q;
        fc_d    = fc_q;
        first_d = first_q;
        ls_d    = 1'b0;
        fs_d    = 1'b0;

        if (bus.Enable) begin
            h_d   = h_nxt;
            v_d   = v_nxt;
            den_d = den_nxt;
            px_d  = den_nxt ? h_nxt : COORD_OFF;
            ln_d  = den_nxt ? v_nxt : COORD_OFF;
            hs_d  = ((h_nxt >= HS_BEGIN) && (h_nxt < HS_END)) ? SYNC_ON : SYNC_OFF;
            vs_d  = ((v_nxt >= VS_BEGIN) && (v_nxt < VS_END)) ? SYNC_ON : SYNC_OFF;
            ls_d  = (h_nxt == 16'd0);
            fs_d  = (h_nxt == 16'd0) && (v_nxt == 16'd0);
            // The first frame start after reset opens a frame; it completes none.
            if (fs_d) begin
                if (first_q) begin
                    first_d = 1'b0;
                end else begin
                    fc_d = fc_q + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge PixelClk or posedge Reset) begin
        if (Reset) begin
            h_q     <= H_LAST;
            v_q     <= V_LAST;
            px_q    <= COORD_OFF;
            ln_q    <= COORD_OFF;
            den_q   <= 1'b0;
            hs_q    <= SYNC_OFF;
            vs_q    <= SYNC_OFF;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
            fc_q    <= 16'd0;
            first_q <= 1'b1;
        end else begin
            h_q     <= h_d;
            v_q     <= v_d;
            px_q    <= px_d;
            ln_q    <= ln_d;
            den_q   <= den_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            ls_q    <= ls_d;
            fs_q    <= fs_d;
            fc_q    <= fc_d;
            first_q <= first_d;
        end
    end

    assign bus.PixelCount = px_q;
    assign bus.LineCount  = ln_q;
    assign bus.LCD_DEN    = den_q;
    assign bus.LCD_HSYNC  = hs_q;
    assign bus.LCD_VSYNC  = vs_q;
    assign bus.LineStart  = ls_q;
    assign bus.FrameStart = fs_q;
    assign bus.FrameCount = fc_q;

endmodule
`default_nettype wire
